horner_poly_stage: RTL
======================

// Module: horner_poly_stage
// PURPOSE
//  Polynomial evaluation stage of the sine datapath, directly downstream of the avail/get pipeline stage.
//  Takes one signed fixed-point argument x per transaction and evaluates p(x)=sum C[i]*x^i by Horner's rule.
//  It uses one iterative multiply-accumulate, N-1 cycles per sample.
//  Presents the result on an avail/get output port with full back-pressure.
// PARAMETERS
//  DATA_WIDTH   52   width of x, coefficients and result; signed two's complement
//  FRAC         50   fractional bits of all operands/results (Q(DATA_WIDTH-FRAC).FRAC)
//  N            5    number of coefficients (polynomial degree N-1); legal range N>=2
//  COEFF_ARRAY  '0   [N*DATA_WIDTH-1:0]; C[i] = COEFF_ARRAY[i*DATA_WIDTH +: DATA_WIDTH]; C[0] is the constant term
// PORTS
//  clk         in   1           single clock, all logic on posedge
//  rst         in   1           reset; one clock; reset is synchronous and active-high
//  pre_avail   in   1           upstream has a valid x on pre_data
//  pre_get     out  1           stage takes x; transfer when pre_avail && pre_get
//  pre_data    in   DATA_WIDTH  argument x
//  post_avail  out  1           result valid on post_data
//  post_get    in   1           downstream takes result; transfer when post_avail && post_get
//  post_data   out  DATA_WIDTH  p(x)
//  post_ovf    out  1           qualified by post_avail: an overflow occurred in this evaluation
// BEHAVIOUR
//  Reset: state=IDLE, acc=0, idx=0, post_avail=0, post_data=0, post_ovf=0. pre_get forced 0 while rst=1.
//  FSM (3 states):
//   IDLE: pre_get=1. On the transfer edge: x<=pre_data, acc<=C[N-1], idx<=N-2, ovf<=0, go to CALC.
//   CALC: pre_get=0. Each edge: acc<=mac(acc,x,C[idx]). If idx==0, go to DONE; else idx<=idx-1.
//   DONE: post_avail=1, post_data=acc, post_ovf=ovf.
//    On post_get: if pre_avail, accept the new x as in IDLE and go to CALC; otherwise go to IDLE.
//  pre_get in DONE = post_get (combinational path post_get->pre_get is permitted).
//  Latency: the accept edge plus N-1 CALC edges; post_avail is high in the cycle after the (N-1)th CALC edge.
//  Throughput: 1 sample per N cycles with pre_avail=post_get=1 continuously.
//  mac(a,x,c): p = a*x, full 2*DATA_WIDTH signed product; p >>> FRAC (floor, no rounding); s = p_shifted + c.
//   Overflow when p_shifted is not representable in DATA_WIDTH bits, or when s overflows.
//   Any overflow in any step sets ovf (sticky for the evaluation).
//  Back-pressure: in DONE with post_get=0, post_data and post_ovf hold stable and no input is taken.
//  Mid-operation reset: the in-flight sample is discarded. State returns to IDLE; post_avail=0 in the cycle after rst.
//  pre_data is sampled only on a transfer edge; changes at any other time are ignored.
// CONFIGURATION
//  HORNER_SAT_EN defined:
//   - an overflowing step saturates to 2^(DATA_WIDTH-1)-1 or -2^(DATA_WIDTH-1), by the sign of the true result;
//   - an overflowing p_shifted saturates the same way before the add.
//  Not defined: overflowing values wrap (truncate to the low DATA_WIDTH bits).
//  post_ovf is reported identically in both builds.
// TESTING  (DATA_WIDTH=16, FRAC=12, N=3, C0=0x1000, C1=0x0800, C2=0x0400)
//  x=0x1000 -> post_data=0x1C00, post_ovf=0, post_avail high 3 cycles after the accept edge.
//  x=0xF000 (-1.0) -> 0x0C00; x=0x0000 -> 0x1000; all post_ovf=0.
//  x=0x7FFF -> post_ovf=1; post_data=0x4FF5 without HORNER_SAT_EN, 0x7FFF with it.
//  post_get=0 for 10 cycles in DONE -> post_avail=1, post_data stable, pre_get=0; a single transfer afterwards.
//  pre_avail=post_get=1 with an incrementing x stream -> accepts every 3 cycles; results in order; no loss or duplicates.
//  rst=1 for 1 cycle during CALC -> post_avail=0, pre_get=1 after rst falls; the next x evaluates correctly.

Source files
------------

// File: rtl/horner_poly_stage_if.sv
// Avail/get handshake bundle for the Horner polynomial stage: upstream argument
// channel (pre_*) and downstream result channel (post_*).
interface horner_poly_stage_if #(
  parameter int DATA_WIDTH = 52
);
  logic                  pre_avail;
  logic                  pre_get;
  logic [DATA_WIDTH-1:0] pre_data;
  logic                  post_avail;
  logic                  post_get;
  logic [DATA_WIDTH-1:0] post_data;
  logic                  post_ovf;

  // master drives arguments in and consumes results; slave is the stage itself
  modport master (
    output pre_avail, pre_data, post_get,
    input  pre_get, post_avail, post_data, post_ovf
  );

  modport slave (
    input  pre_avail, pre_data, post_get,
    output pre_get, post_avail, post_data, post_ovf
  );
endinterface

// File: rtl/horner_poly_stage.sv
// Iterative Horner evaluator p(x)=sum C[i]*x^i, one MAC per cycle, avail/get in and out.
// Optional macro HORNER_SAT_EN: saturate overflowing steps instead of wrapping.
module horner_poly_stage #(
  parameter int                          DATA_WIDTH  = 52,
  parameter int                          FRAC        = 50,
  parameter int                          N           = 5,
  parameter logic [N*DATA_WIDTH-1:0]     COEFF_ARRAY = '0
) (
  input  logic               clk,
  input  logic               rst,
  horner_poly_stage_if.slave bus
);

  localparam int PW    = 2 * DATA_WIDTH;
  localparam int IDX_W = (N > 2) ? $clog2(N) : 1;

  localparam logic [DATA_WIDTH-1:0] C_TOP =
    COEFF_ARRAY[(N-1)*DATA_WIDTH +: DATA_WIDTH];
  localparam logic [IDX_W-1:0]      IDX_START = IDX_W'(N - 2);

`ifdef HORNER_SAT_EN
  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                       state;
  state_t                       state_nxt;
  logic signed [DATA_WIDTH-1:0] acc;
  logic signed [DATA_WIDTH-1:0] x;
  logic        [IDX_W-1:0]      idx;
  logic                         ovf;
  logic                         take;

  logic        [DATA_WIDTH-1:0] coeff;
  logic signed [PW-1:0]         prod;
  logic signed [PW-1:0]         p_sh;
  logic        [DATA_WIDTH-1:0] p_use;
  logic        [DATA_WIDTH:0]   sum;
  logic                         p_ovf;
  logic                         s_ovf;
  logic        [DATA_WIDTH-1:0] mac_res;

  assign take = bus.pre_avail && bus.pre_get;

  // ---------------------------------------------------------------- state register
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of its inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---------------------------------------------------------------- next-state logic
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE: if (take) state_nxt = CALC;
      CALC: if (idx == '0) state_nxt = DONE;
      DONE: if (bus.post_get) state_nxt = take ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- output logic
  always_comb begin
    bus.pre_get    = 1'b0;
    bus.post_avail = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE: bus.pre_get = 1'b1;
        DONE: begin
          bus.post_avail = 1'b1;
          // Combinational get-through lets a new sample start on the same edge the result leaves.
          bus.pre_get    = bus.post_get;
        end
        default: ;
      endcase
    end
  end

  assign bus.post_data = acc;
  assign bus.post_ovf  = ovf;

  // ---------------------------------------------------------------- multiply-accumulate step
  always_comb begin
    coeff = COEFF_ARRAY[idx*DATA_WIDTH +: DATA_WIDTH];
    prod  = PW'(acc) * PW'(x);
    p_sh  = prod >>> FRAC;
    // The shifted product fits only if its upper bits are a pure sign extension.
    p_ovf = !((&p_sh[PW-1:DATA_WIDTH-1]) || !(|p_sh[PW-1:DATA_WIDTH-1]));
`ifdef HORNER_SAT_EN
    if (p_ovf) p_use = p_sh[PW-1] ? SAT_MIN : SAT_MAX;
    else       p_use = p_sh[DATA_WIDTH-1:0];
`else
    p_use = p_sh[DATA_WIDTH-1:0];
`endif
    sum   = {p_use[DATA_WIDTH-1], p_use} + {coeff[DATA_WIDTH-1], coeff};
    s_ovf = sum[DATA_WIDTH] ^ sum[DATA_WIDTH-1];
`ifdef HORNER_SAT_EN
    if (s_ovf) mac_res = sum[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
    else       mac_res = sum[DATA_WIDTH-1:0];
`else
    mac_res = sum[DATA_WIDTH-1:0];
`endif
  end

  // ---------------------------------------------------------------- datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      x   <= '0;
      idx <= '0;
      ovf <= 1'b0;
    end else if (take) begin
      x   <= bus.pre_data;
      acc <= C_TOP;
      idx <= IDX_START;
      ovf <= 1'b0;
    end else if (state == CALC) begin
      acc <= mac_res;
      ovf <= ovf | p_ovf | s_ovf;
      if (idx != '0) idx <= idx - 1'b1;
    end
  end

endmodule
